pixel_memory_reader: RTL and testbench
======================================

# pixel_memory_reader

Streams a contiguous run of pixels out of the 1024 x 8 pixel memory through its read port and presents them on a valid/ready pixel stream. It sits downstream of the pixel memory, driving the memory's port-B address and consuming its read data. A 2-entry output buffer absorbs the memory's 1-cycle read latency, so the block sustains one pixel per cycle under continuous ready and loses no data under backpressure.

## Interface
- ADDR_WIDTH, 10, pixel memory address width (1024 locations)
- DATA_WIDTH, 8, pixel width
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle request to begin a run; sampled only in IDLE
- base_addr  in  10  first pixel address; sampled with start
- length  in  11  pixel count, 0..1024; sampled with start; values >1024 clamp to 1024
- mem_addr  out  10  read address to pixel memory port B
- mem_q  in  8  pixel memory read data, valid the cycle after mem_addr is presented
- pixel_data  out  8  stream data
- pixel_valid  out  1  stream data valid
- pixel_ready  in  1  consumer accepts; transfer = pixel_valid & pixel_ready
- pixel_last  out  1  high with the final pixel of the run
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  single-cycle pulse at end of run

## Operation
- States: IDLE, RUN, DONE.
- IDLE: busy=0. On start, latch base_addr and clamped length, then go to RUN. If length=0, go to DONE and issue no reads.
- RUN: issue counter i (0..len-1) and accept counter track progress. Read address = (base + i) mod 1024, so 0x3FF wraps to 0x000.
- Issue rule: issue a read this cycle iff i < len and (occupancy + in_flight - pop) < 2. Here occupancy is 0..2 buffer entries, in_flight is 0/1 (a read issued last cycle), and pop = pixel_valid & pixel_ready.
- mem_addr is driven combinationally from the issue address when issuing. Otherwise it holds its last value.
- The in-flight read's mem_q is written into the buffer the following cycle. The buffer is 2-deep, FIFO-ordered, and never overflows.
- pixel_valid = buffer non-empty. pixel_data = buffer head. Both are stable while pixel_valid & !pixel_ready.
- pixel_last = pixel_valid and head is pixel number len-1.
- When the last pixel transfers, go to DONE.
- DONE: done=1 and busy=0 for one cycle, then IDLE.
- start outside IDLE is ignored. Memory write port is not driven by this block.
- Simultaneous push and pop leaves occupancy unchanged.

## Timing
- Reset values: mem_addr=0, pixel_data=0, pixel_valid=0, pixel_last=0, busy=0, done=0. State=IDLE, buffer empty, counters 0.
- rst during any state: the next cycle matches the reset values and the buffer is flushed. Any in-flight read data is discarded.
- Run start timing, with start sampled at edge 0:
  - Cycle 1: busy=1; first read issued.
  - Cycle 2: mem_q valid.
  - Cycle 3: pixel_valid=1.
- Start-to-first-valid latency: 3 cycles.
- With pixel_ready held high, pixels appear on consecutive cycles. The last transfer is in cycle len+2, and done is in cycle len+3.
- length=0: done in cycle 1, busy stays 0, no pixel_valid.
- Backpressure: a stalled head holds data. At most one more read completes into the buffer. Issues resume the cycle a pop makes room under the issue rule.

## Test plan
- Preload mem[a]=a[7:0]; base=0x010, length=4, pixel_ready=1 -> pixel_data 0x10,0x11,0x12,0x13 on cycles 3-6; pixel_last with 0x13; done pulse cycle 7; busy 1 on cycles 1-6.
- Wrap: base=0x3FE, length=4 -> mem_addr sequence 0x3FE,0x3FF,0x000,0x001; pixel_data 0xFE,0xFF,0x00,0x01.
- Backpressure: length=8, pixel_ready low for cycles 4-8 -> 0x10 transfers in cycle 3 and 0x11 holds stable through the stall; buffer never exceeds 2; issues pause; output is exactly 0x10..0x17 in order, no duplicates or drops. Also cover random ready at 50%, checked against a reference model.
- length=0 -> done in cycle 1, no pixel_valid. length=1100 -> exactly 1024 pixels, pixel_last on the 1024th, address wraps to base.
- rst asserted after 3 pixels transfer -> next cycle all outputs at reset values; a fresh start (base=0x020, length=2) yields 0x20,0x21 with normal latency.
- start pulsed during RUN with a different base -> ignored; the original run completes unchanged.

Source files
------------

// File: rtl/pixel_memory_reader.sv
// pixel_memory_reader: streams a contiguous run of pixels from the 1024 x 8
// pixel memory (port B, 1-cycle read latency) onto a valid/ready stream.
// A 2-entry output buffer absorbs the read latency so the block sustains one
// pixel per cycle and loses nothing under backpressure.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; start latches base and clamped length
// RUN   | issuing reads and streaming pixels until the last one transfers
// DONE  | one-cycle done pulse, then back to IDLE
module pixel_memory_reader #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic [DATA_WIDTH-1:0] pixel_data,
    output logic                  pixel_valid,
    input  logic                  pixel_ready,
    output logic                  pixel_last,
    output logic                  busy,
    output logic                  done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [ADDR_WIDTH:0] MAX_LEN = (ADDR_WIDTH+1)'(1 << ADDR_WIDTH);

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic [ADDR_WIDTH:0]   issue_cnt_q, issue_cnt_d;
    logic [ADDR_WIDTH:0]   acc_cnt_q, acc_cnt_d;
    logic                  in_flight_q, in_flight_d;
    logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
    logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            count_q, count_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;

    logic                  pop;
    logic                  push;
    logic                  issue;
    logic                  last_pop;
    logic [2:0]            occ_after;
    logic [ADDR_WIDTH-1:0] issue_addr;

    // Stream outputs, issue decision and read address.
    always_comb begin
        pixel_valid = (count_q != 2'd0);
        pixel_data  = rd_ptr_q ? buf1_q : buf0_q;
        pixel_last  = pixel_valid && (acc_cnt_q == len_q - 1'b1);
        busy        = (state_q == S_RUN);
        done        = (state_q == S_DONE);
        pop         = pixel_valid & pixel_ready;
        push        = in_flight_q;
        last_pop    = pop && (acc_cnt_q == len_q - 1'b1);
        // Occupancy the buffer would have after this cycle without a new issue;
        // pop implies count >= 1, so this never underflows.
        occ_after   = {1'b0, count_q} + {2'b0, in_flight_q} - {2'b0, pop};
        issue       = (state_q == S_RUN) && (issue_cnt_q < len_q) && (occ_after < 3'd2);
        issue_addr  = base_q + issue_cnt_q[ADDR_WIDTH-1:0];
        mem_addr    = issue ? issue_addr : mem_addr_q;
    end

    // Next-state for FSM, counters and the 2-entry output buffer.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        len_d       = len_q;
        issue_cnt_d = issue_cnt_q;
        acc_cnt_d   = acc_cnt_q;
        in_flight_d = issue;
        buf0_d      = buf0_q;
        buf1_d      = buf1_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        mem_addr_d  = mem_addr;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d      = base_addr;
                    len_d       = (length > MAX_LEN) ? MAX_LEN : length;
                    issue_cnt_d = '0;
                    acc_cnt_d   = '0;
                    state_d     = (length == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (issue) issue_cnt_d = issue_cnt_q + 1'b1;
                if (pop)   acc_cnt_d   = acc_cnt_q + 1'b1;
                if (last_pop) state_d  = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (push) begin
            if (wr_ptr_q) buf1_d = mem_q;
            else          buf0_d = mem_q;
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) rd_ptr_d = ~rd_ptr_q;
        count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    // State registers; reset flushes the buffer and drops any in-flight read.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            len_q       <= '0;
            issue_cnt_q <= '0;
            acc_cnt_q   <= '0;
            in_flight_q <= 1'b0;
            buf0_q      <= '0;
            buf1_q      <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= '0;
            mem_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            len_q       <= len_d;
            issue_cnt_q <= issue_cnt_d;
            acc_cnt_q   <= acc_cnt_d;
            in_flight_q <= in_flight_d;
            buf0_q      <= buf0_d;
            buf1_q      <= buf1_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            mem_addr_q  <= mem_addr_d;
        end
    end

endmodule

// File: tb/tb_pixel_memory_reader.sv
// Scoreboard bench for pixel_memory_reader: the stimulus pushes expected
// {last, data} pairs into a queue, a negedge monitor pops and compares on
// every transfer and also checks that stalled data stays stable.
module tb_pixel_memory_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  base_addr;
    logic [10:0] length;
    logic [9:0]  mem_addr;
    logic [7:0]  mem_q;
    logic [7:0]  pixel_data;
    logic        pixel_valid;
    logic        pixel_ready;
    logic        pixel_last;
    logic        busy;
    logic        done;

    logic [7:0]  mem [1024];
    logic [8:0]  exp_q [$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          t0 = 0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = '0;

    pixel_memory_reader dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .base_addr   (base_addr),
        .length      (length),
        .mem_addr    (mem_addr),
        .mem_q       (mem_q),
        .pixel_data  (pixel_data),
        .pixel_valid (pixel_valid),
        .pixel_ready (pixel_ready),
        .pixel_last  (pixel_last),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Pixel memory model with a registered port-B read.
    always @(posedge clk) mem_q <= mem[mem_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc - t0);
        end
    endtask

    // Monitor: compare each transfer against the scoreboard, check stall stability.
    always @(negedge clk) begin
        logic [8:0] e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", {31'd0, pixel_valid}, 32'd1);
                chk("stall_data", {24'd0, pixel_data}, {24'd0, prev_data});
            end
            if (pixel_valid && pixel_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pixel: got 0x%0h expected none", pixel_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("pixel_data", {24'd0, pixel_data}, {24'd0, e[7:0]});
                    chk("pixel_last", {31'd0, pixel_last}, {31'd0, e[8]});
                end
            end
            prev_stall = pixel_valid && !pixel_ready;
            prev_data  = pixel_data;
        end
    end

    // Push expected pixels, pulse start; returns at cycle 1 (+1 time unit).
    task automatic do_start(input logic [9:0] b, input logic [10:0] l);
        int n;
        logic [9:0] a;
        n = (l > 11'd1024) ? 1024 : int'(l);
        for (int k = 0; k < n; k++) begin
            a = b + 10'(k);
            exp_q.push_back({(k == n - 1), a[7:0]});
        end
        base_addr = b;
        length    = l;
        start     = 1'b1;
        @(posedge clk);
        #1;
        t0    = cyc - 1;
        start = 1'b0;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Wait for done (bounded), checking busy each cycle; optional random ready.
    task automatic wait_done(input int exp_cyc, input bit rnd);
        while (!done && (cyc - t0) < 3000) begin
            chk("busy_run", {31'd0, busy}, 32'd1);
            if (rnd) pixel_ready = 1'($urandom_range(0, 1));
            step();
        end
        chk("done_seen", {31'd0, done}, 32'd1);
        chk("busy_at_done", {31'd0, busy}, 32'd0);
        if (exp_cyc >= 0) chk("done_cycle", cyc - t0, exp_cyc);
        chk("queue_drained", exp_q.size(), 32'd0);
        pixel_ready = 1'b1;
        step();
        chk("done_one_cycle", {31'd0, done}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i);
        rst = 1'b1;
        start = 1'b0;
        base_addr = '0;
        length = '0;
        pixel_ready = 1'b1;
        repeat (3) step();
        chk("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
        chk("rst_pixel_data", {24'd0, pixel_data}, 32'd0);
        chk("rst_valid", {31'd0, pixel_valid}, 32'd0);
        chk("rst_last", {31'd0, pixel_last}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        step();

        // Basic run, ready high: first valid at cycle 3, done at cycle 7.
        do_start(10'h010, 11'd4);
        chk("c1_busy", {31'd0, busy}, 32'd1);
        chk("c1_mem_addr", {22'd0, mem_addr}, 32'h010);
        chk("c1_valid", {31'd0, pixel_valid}, 32'd0);
        step();
        chk("c2_valid", {31'd0, pixel_valid}, 32'd0);
        step();
        chk("c3_valid", {31'd0, pixel_valid}, 32'd1);
        wait_done(7, 1'b0);

        // Address wrap at the top of memory.
        do_start(10'h3FE, 11'd4);
        chk("wrap_c1_addr", {22'd0, mem_addr}, 32'h3FE);
        step();
        chk("wrap_c2_addr", {22'd0, mem_addr}, 32'h3FF);
        step();
        chk("wrap_c3_addr", {22'd0, mem_addr}, 32'h000);
        step();
        chk("wrap_c4_addr", {22'd0, mem_addr}, 32'h001);
        wait_done(7, 1'b0);

        // Backpressure: ready low for cycles 4-8.
        do_start(10'h010, 11'd8);
        step();
        step();
        step();
        pixel_ready = 1'b0;
        repeat (4) step();
        chk("bp_c8_valid", {31'd0, pixel_valid}, 32'd1);
        chk("bp_c8_data", {24'd0, pixel_data}, 32'h11);
        chk("bp_c8_addr_held", {22'd0, mem_addr}, 32'h012);
        step();
        pixel_ready = 1'b1;
        wait_done(-1, 1'b0);

        // Random ready, crossing the wrap point.
        do_start(10'h3F0, 11'd40);
        wait_done(-1, 1'b1);

        // Zero length: done in cycle 1, no reads or pixels.
        do_start(10'h055, 11'd0);
        chk("len0_done", {31'd0, done}, 32'd1);
        chk("len0_busy", {31'd0, busy}, 32'd0);
        chk("len0_valid", {31'd0, pixel_valid}, 32'd0);
        wait_done(1, 1'b0);

        // Oversized length clamps to 1024 pixels.
        do_start(10'h100, 11'd1100);
        wait_done(1027, 1'b0);

        // Reset mid-run after three transfers, then a fresh run.
        do_start(10'h010, 11'd8);
        repeat (5) step();
        rst = 1'b1;
        pixel_ready = 1'b0;
        exp_q.delete();
        step();
        chk("mrst_mem_addr", {22'd0, mem_addr}, 32'd0);
        chk("mrst_pixel_data", {24'd0, pixel_data}, 32'd0);
        chk("mrst_valid", {31'd0, pixel_valid}, 32'd0);
        chk("mrst_last", {31'd0, pixel_last}, 32'd0);
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        pixel_ready = 1'b1;
        step();
        do_start(10'h020, 11'd2);
        step();
        chk("fresh_c2_valid", {31'd0, pixel_valid}, 32'd0);
        step();
        chk("fresh_c3_valid", {31'd0, pixel_valid}, 32'd1);
        chk("fresh_c3_data", {24'd0, pixel_data}, 32'h20);
        wait_done(5, 1'b0);

        // Start during RUN is ignored.
        do_start(10'h010, 11'd4);
        base_addr = 10'h200;
        length = 11'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(7, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
